// File: rtl/wm8731_pkg.sv
// Shared encodings and constants for the WM8731 codec control path.
package wm8731_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 9;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam logic [ADDR_W-1:0] R_LINVOL  = 7'h00;
    localparam logic [ADDR_W-1:0] R_RINVOL  = 7'h01;
    localparam logic [ADDR_W-1:0] R_LHPOUT  = 7'h02;
    localparam logic [ADDR_W-1:0] R_RHPOUT  = 7'h03;
    localparam logic [ADDR_W-1:0] R_ANAPATH = 7'h04;
    localparam logic [ADDR_W-1:0] R_DIGPATH = 7'h05;
    localparam logic [ADDR_W-1:0] R_PWRDN   = 7'h06;
    localparam logic [ADDR_W-1:0] R_DIGFMT  = 7'h07;
    localparam logic [ADDR_W-1:0] R_SAMPLE  = 7'h08;
    localparam logic [ADDR_W-1:0] R_ACTIVE  = 7'h09;
    localparam logic [ADDR_W-1:0] R_RESET   = 7'h0F;

    function automatic logic [WORD_W-1:0] codec_word(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {addr, data};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping to the lowest set request.
module rr_pick
    import wm8731_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_v;

    // Descending scan so the lowest qualifying index is the one kept.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_v   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= ptr_i) begin
                    hi_idx = IDX_W'(i);
                    hi_v   = 1'b1;
                end
            end
        end
    end

    assign valid_o = |req_i;
    assign idx_o   = hi_v ? hi_idx : lo_idx;

endmodule

// File: rtl/wm8731_i2c_arbiter.sv
// Round-robin sharing of the IIC write engine between codec requesters.
// Define WM8731_ARB_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES.
module wm8731_i2c_arbiter
    import wm8731_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                      MCLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [WORD_W*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]        ACK,
    output logic                      ERR,
    output logic                      BUSY,
    output logic [IDX_W-1:0]          GRANT_ID,
    output logic                      IIC_ENABLE,
    output logic [WORD_W-1:0]         IIC_DATA,
    input  logic                      IIC_FINISHED
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    arb_state_t       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] grant_q;
    logic [GAP_W-1:0] gap_q;
    logic             fin_q;
    logic             first_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] ack_d;
    logic             err_q;
    logic             en_q;
    logic [WORD_W-1:0] data_q;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_v;
    logic [WORD_W-1:0] pick_word;
    logic              fin_rise;
    logic              done;
    logic              to_hit;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_v)
    );

    assign fin_rise = IIC_FINISHED & ~fin_q;
    // An edge in the entry cycle is a leftover from the previous transfer.
    assign done  = (state_q == ST_XFER) & fin_rise & ~first_q;
    assign ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0
                 : grant_q + IDX_W'(1);

    always_comb begin
        pick_word = '0;
        ack_d     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_word = REQ_DATA[WORD_W*i +: WORD_W];
            end
            ack_d[i] = (grant_q == IDX_W'(i));
        end
    end

`ifdef WM8731_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_q;

    assign to_hit = (state_q == ST_XFER)
                  & (to_q == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge MCLK) begin
        if (!RESET || state_q != ST_XFER) begin
            to_q <= '0;
        end else begin
            to_q <= to_q + TO_W'(1);
        end
    end
`else
    logic unused_to;

    assign unused_to = (TIMEOUT_CYCLES != 0);
    assign to_hit    = 1'b0;
`endif

    always_ff @(posedge MCLK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            gap_q   <= '0;
            fin_q   <= 1'b0;
            first_q <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            fin_q   <= IIC_FINISHED;
            ack_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_v) begin
                        data_q  <= pick_word;
                        grant_q <= pick_idx;
                        en_q    <= 1'b1;
                        first_q <= 1'b1;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (done || to_hit) begin
                        ack_q   <= ack_d;
                        err_q   <= ~done;
                        en_q    <= 1'b0;
                        ptr_q   <= ptr_d;
                        gap_q   <= GAP_LOAD;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ACK        = ack_q;
    assign ERR        = err_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign GRANT_ID   = grant_q;
    assign IIC_ENABLE = en_q;
    assign IIC_DATA   = data_q;

endmodule

// File: tb/tb_wm8731_i2c_arbiter.sv
// Bench for wm8731_i2c_arbiter: directed scenarios plus random traffic,
// all cycles compared against a transaction-level model.
module tb_wm8731_i2c_arbiter;

    localparam int N   = 2;
    localparam int GAP = 16;
    localparam int TO  = 100;

    logic            MCLK = 1'b0;
    logic            RESET = 1'b0;
    logic [N-1:0]    REQ = '0;
    logic [16*N-1:0] REQ_DATA = '0;
    logic            IIC_FINISHED = 1'b0;
    logic [N-1:0]    ACK;
    logic            ERR;
    logic            BUSY;
    logic [2:0]      GRANT_ID;
    logic            IIC_ENABLE;
    logic [15:0]     IIC_DATA;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #10 MCLK = ~MCLK;

    wm8731_i2c_arbiter #(
        .NUM_REQ        (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .MCLK         (MCLK),
        .RESET        (RESET),
        .REQ          (REQ),
        .REQ_DATA     (REQ_DATA),
        .ACK          (ACK),
        .ERR          (ERR),
        .BUSY         (BUSY),
        .GRANT_ID     (GRANT_ID),
        .IIC_ENABLE   (IIC_ENABLE),
        .IIC_DATA     (IIC_DATA),
        .IIC_FINISHED (IIC_FINISHED)
    );

    // Model: a transfer is "owned" from grant until ack; after ack the
    // block stays busy for GAP cycles, then may grant again.
    bit          m_busy;
    bit          m_xfer;
    bit          m_fin_prev;
    int          m_age;
    int          m_gap;
    int          m_ptr;
    logic [N-1:0] e_ack;
    logic        e_err;
    logic        e_en;
    logic [2:0]  e_grant;
    logic [15:0] e_data;

    always @(posedge MCLK) begin : model
        bit rise;
        bit found;
        bit to_abort;
        int win;
        rise = IIC_FINISHED && !m_fin_prev;
        m_fin_prev = IIC_FINISHED;
        e_ack = '0;
        e_err = 1'b0;
        if (!RESET) begin
            m_busy = 0; m_xfer = 0; m_ptr = 0; m_fin_prev = 0;
            e_en = 0; e_grant = 0; e_data = 0;
        end else if (!m_busy) begin
            found = 0;
            win = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && REQ[(m_ptr + k) % N]) begin
                    found = 1;
                    win = (m_ptr + k) % N;
                end
            end
            if (found) begin
                e_grant = 3'(win);
                e_data = REQ_DATA[16*win +: 16];
                e_en = 1; m_busy = 1; m_xfer = 1; m_age = 0;
            end
        end else if (m_xfer) begin
            to_abort = 0;
`ifdef WM8731_ARB_TIMEOUT_EN
            to_abort = (m_age == TO);
`endif
            if ((rise && m_age > 0) || to_abort) begin
                e_ack[e_grant] = 1'b1;
                e_err = !(rise && m_age > 0);
                e_en = 0;
                m_ptr = (int'(e_grant) + 1) % N;
                m_xfer = 0;
                m_gap = GAP;
            end else begin
                m_age++;
            end
        end else begin
            m_gap--;
            if (m_gap == 0) m_busy = 0;
        end
    end

    always @(negedge MCLK) begin
        if (chk_en) begin
            checks++;
            if (ACK !== e_ack || ERR !== e_err || BUSY !== m_busy ||
                GRANT_ID !== e_grant || IIC_ENABLE !== e_en ||
                IIC_DATA !== e_data) begin
                errors++;
                if (errors < 20)
                    $display("FAIL model t=%0t ack %b/%b err %b/%b busy %b/%b gnt %0d/%0d en %b/%b data %h/%h",
                             $time, ACK, e_ack, ERR, e_err, BUSY, m_busy,
                             GRANT_ID, e_grant, IIC_ENABLE, e_en,
                             IIC_DATA, e_data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        while (IIC_ENABLE !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({name, "_en"}, 32'(IIC_ENABLE), 32'd1);
    endtask

    task automatic pulse_reset();
        RESET = 1'b0;
        REQ = '0;
        step();
        RESET = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;
        int ord [4];
        ord = '{0, 1, 0, 1};

        step();
        chk_en = 1'b1;
        step();
        RESET = 1'b1;
        chk("rst_ack", 32'(ACK), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_en", 32'(IIC_ENABLE), 32'd0);
        chk("rst_data", 32'(IIC_DATA), 32'd0);
        chk("rst_grant", 32'(GRANT_ID), 32'd0);

        // single request
        REQ = 2'b01;
        REQ_DATA[15:0] = 16'h0417;
        step();
        chk("single_en", 32'(IIC_ENABLE), 32'd1);
        chk("single_data", 32'(IIC_DATA), 32'h0417);
        repeat (499) step();
        IIC_FINISHED = 1'b1;
        step();
        chk("single_ack", 32'(ACK), 32'b01);
        REQ = '0;
        n = 0;
        while (BUSY === 1'b1 && n < 50) begin
            n++;
            step();
        end
        chk("gap_len", n, GAP);
        IIC_FINISHED = 1'b0;

        // contention, pointer at 0
        pulse_reset();
        REQ = 2'b11;
        REQ_DATA = {16'h0479, 16'h0E53};
        for (int t = 0; t < 4; t++) begin
            wait_en("rr");
            chk("rr_grant", 32'(GRANT_ID), ord[t]);
            chk("rr_data", 32'(IIC_DATA),
                ord[t] == 0 ? 32'h0E53 : 32'h0479);
            repeat (20) step();
            IIC_FINISHED = 1'b1;
            step();
            chk("rr_ack", 32'(ACK), ord[t] == 0 ? 32'b01 : 32'b10);
            IIC_FINISHED = 1'b0;
        end
        REQ = '0;
        repeat (20) step();

        // stale FINISHED level held into the next grant
        REQ = 2'b01;
        REQ_DATA[15:0] = 16'h1234;
        wait_en("stale1");
        repeat (10) step();
        IIC_FINISHED = 1'b1;
        step();
        chk("stale_first_ack", 32'(ACK), 32'b01);
        wait_en("stale2");
        acks = 0;
        repeat (50) begin
            step();
            if (ACK !== '0) acks++;
        end
        chk("stale_noack", acks, 0);
        chk("stale_busy", 32'(BUSY), 32'd1);
        IIC_FINISHED = 1'b0;
        step();
        IIC_FINISHED = 1'b1;
        step();
        chk("stale_fresh_ack", 32'(ACK), 32'b01);
        REQ = '0;
        IIC_FINISHED = 1'b0;
        repeat (20) step();

        // rising edge exactly in the entry cycle
        REQ = 2'b10;
        REQ_DATA[31:16] = 16'h0C1F;
        wait_en("entry");
        IIC_FINISHED = 1'b1;
        acks = 0;
        repeat (30) begin
            step();
            if (ACK !== '0) acks++;
        end
        chk("entry_noack", acks, 0);
        IIC_FINISHED = 1'b0;
        step();
        IIC_FINISHED = 1'b1;
        step();
        chk("entry_ack", 32'(ACK), 32'b10);
        REQ = '0;
        IIC_FINISHED = 1'b0;
        repeat (20) step();

        // reset mid-transfer
        REQ = 2'b10;
        REQ_DATA[31:16] = 16'h0A5A;
        wait_en("rstx");
        repeat (200) step();
        RESET = 1'b0;
        REQ = '0;
        step();
        chk("rstx_en", 32'(IIC_ENABLE), 32'd0);
        chk("rstx_ack", 32'(ACK), 32'd0);
        chk("rstx_busy", 32'(BUSY), 32'd0);
        chk("rstx_grant", 32'(GRANT_ID), 32'd0);
        RESET = 1'b1;
        step();

        // withdrawal mid-transfer
        REQ = 2'b10;
        REQ_DATA[31:16] = 16'h0E02;
        wait_en("wd");
        repeat (10) step();
        REQ = '0;
        repeat (10) step();
        IIC_FINISHED = 1'b1;
        step();
        chk("wd_ack", 32'(ACK), 32'b10);
        IIC_FINISHED = 1'b0;
        repeat (40) step();
        chk("wd_idle_busy", 32'(BUSY), 32'd0);
        chk("wd_idle_en", 32'(IIC_ENABLE), 32'd0);

        // FINISHED never rises
        REQ = 2'b01;
        REQ_DATA[15:0] = 16'h1201;
        step();
        chk("to_en", 32'(IIC_ENABLE), 32'd1);
        n = 0;
        while (ACK === '0 && n < 300) begin
            step();
            n++;
        end
`ifdef WM8731_ARB_TIMEOUT_EN
        chk("to_latency", n, 101);
        chk("to_ack", 32'(ACK), 32'b01);
        chk("to_err", 32'(ERR), 32'd1);
        REQ = '0;
        repeat (20) step();
`else
        chk("to_wait", n, 300);
        chk("to_busy", 32'(BUSY), 32'd1);
        chk("to_noerr", 32'(ERR), 32'd0);
        pulse_reset();
`endif

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (ACK[i]) begin
                    REQ[i] = 1'($urandom_range(0, 1));
                    REQ_DATA[16*i +: 16] = 16'($urandom);
                end else if (!REQ[i] && $urandom_range(0, 7) == 0) begin
                    REQ[i] = 1'b1;
                    REQ_DATA[16*i +: 16] = 16'($urandom);
                end else if (REQ[i] && $urandom_range(0, 299) == 0) begin
                    REQ[i] = 1'b0;
                end
                if ($urandom_range(0, 49) == 0)
                    REQ_DATA[16*i +: 16] = 16'($urandom);
            end
            if ($urandom_range(0, 14) == 0) IIC_FINISHED = ~IIC_FINISHED;
            RESET = ($urandom_range(0, 799) != 0);
        end
        RESET = 1'b1;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
